// File: rtl/teamd_rx_sequencer.sv
// teamd_rx_sequencer: 7-bit async serial receiver with frame check, held data register and overrun detect
// Ports: CLK clock; nReset sync active-low reset; En receive enable; Rx async serial line (idle high);
//        Ack consumer acknowledge; iD received data; Valid unacknowledged frame held;
//        iLoad / FrameErr / Overrun one-cycle event pulses; Busy FSM not idle.
// Optional parity bit (even parity over data + parity) with `define TEAMD_RX_PARITY_EN.
module teamd_rx_sequencer #(
  parameter int DIV = 8
) (
  input  logic       CLK,
  input  logic       nReset,
  input  logic       En,
  input  logic       Rx,
  input  logic       Ack,
  output logic [6:0] iD,
  output logic       Valid,
  output logic       iLoad,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       Busy
);
  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(DIV - 1);
`ifdef TEAMD_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic rx_m, rx_s, rx_p, tz, fall, done, good, load;
  logic [TW-1:0] tmr;
  logic [2:0] cnt;
  logic [6:0] sh;
  assign tz = tmr == '0;
  assign fall = rx_p & ~rx_s;
  assign done = En && state == STOP && tz;
`ifdef TEAMD_RX_PARITY_EN
  assign good = rx_s & ~(^{sh, par});
`else
  assign good = rx_s;
`endif
  // A held frame may be replaced only when it is acknowledged in the same cycle.
  assign load = done & good & (~Valid | Ack);
  assign Busy = state != IDLE;
  always_ff @(posedge CLK) state <= nReset ? state_n : IDLE;
  always_comb begin
    state_n = state;
    if (!En) state_n = IDLE;
    else
      case (state)
        IDLE:  if (fall) state_n = START;
        START: if (tz) state_n = rx_s ? IDLE : DATA;
`ifdef TEAMD_RX_PARITY_EN
        DATA:  if (tz && cnt == 3'd6) state_n = PAR;
        PAR:   if (tz) state_n = STOP;
`else
        DATA:  if (tz && cnt == 3'd6) state_n = STOP;
`endif
        STOP:  if (tz) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      {rx_m, rx_s, rx_p} <= '1;
      tmr <= '0;
      cnt <= '0;
      sh <= '0;
      iD <= '0;
      Valid <= 1'b0;
      iLoad <= 1'b0;
      FrameErr <= 1'b0;
      Overrun <= 1'b0;
`ifdef TEAMD_RX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
      iLoad <= load;
      FrameErr <= done & ~good;
      Overrun <= done & good & Valid & ~Ack;
      Valid <= load | (Valid & ~Ack);
      if (load) iD <= sh;
      // Timer parks at 0 outside a frame; reload only when the FSM moves on to another bit.
      if (!En) tmr <= '0;
      else if (state == IDLE) tmr <= fall ? HALF : tmr;
      else if (!tz) tmr <= tmr - 1'b1;
      else if (state_n != IDLE) tmr <= FULL;
      if (En && tz && state == START) cnt <= '0;
      if (En && tz && state == DATA) begin
        sh <= {rx_s, sh[6:1]};
        cnt <= cnt + 1'b1;
      end
`ifdef TEAMD_RX_PARITY_EN
      if (En && tz && state == PAR) par <= rx_s;
`endif
    end
  end
endmodule

// File: tb/tb_teamd_rx_sequencer.sv
// tb_teamd_rx_sequencer: scoreboard bench for teamd_rx_sequencer
module tb_teamd_rx_sequencer;
  localparam int DIV = 8;
`ifdef TEAMD_RX_PARITY_EN
  localparam int PX = DIV;
`else
  localparam int PX = 0;
`endif
  logic CLK = 1'b0, nReset = 1'b0, En = 1'b1, Rx = 1'b1, Ack = 1'b0;
  logic [6:0] iD;
  logic Valid, iLoad, FrameErr, Overrun, Busy;
  int errors = 0, checks = 0, cyc = 0;
  int n_load = 0, n_ferr = 0, n_ovr = 0, fall_cyc = 0, valid_cyc = -1;
  logic vprev = 1'b0;
  logic [6:0] e;
  logic [6:0] exp_q[$];

  teamd_rx_sequencer #(.DIV(DIV)) dut (
    .CLK(CLK), .nReset(nReset), .En(En), .Rx(Rx), .Ack(Ack),
    .iD(iD), .Valid(Valid), .iLoad(iLoad), .FrameErr(FrameErr),
    .Overrun(Overrun), .Busy(Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (iLoad) begin
      n_load++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: iD=%h loaded, none expected", iD);
      end else begin
        e = exp_q.pop_front();
        if (iD !== e) begin
          errors++;
          $display("FAIL load_data: iD=%h expected %h", iD, e);
        end
      end
    end
    if (FrameErr) n_ferr++;
    if (Overrun) n_ovr++;
    if (iLoad | FrameErr | Overrun) begin
      checks++;
      if ($countones({iLoad, FrameErr, Overrun}) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: load/ferr/ovr=%b%b%b expected one-hot", iLoad, FrameErr, Overrun);
      end
    end
    if (Valid && !vprev) valid_cyc = cyc;
    vprev = Valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic drive_frame(input logic [6:0] d, input logic stp, input logic pb, input int ncyc, input int ack_at);
    logic [9:0] fr;
    int nb;
`ifdef TEAMD_RX_PARITY_EN
    fr = {stp, pb, d, 1'b0};
    nb = 10;
`else
    fr = {1'b0, stp, d, pb & 1'b0};
    nb = 9;
`endif
    if (ncyc < 0) ncyc = nb * DIV;
    fall_cyc = cyc;
    for (int i = 0; i < ncyc; i++) begin
      Rx = fr[i / DIV];
      Ack = (i == ack_at);
      @(negedge CLK);
    end
    Ack = 1'b0;
    if (ncyc == nb * DIV) Rx = 1'b1;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    @(negedge CLK);
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({iD, Valid, iLoad, FrameErr, Overrun, Busy} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs: {iD,V,L,F,O,B}=%h expected 0", {iD, Valid, iLoad, FrameErr, Overrun, Busy});
    end
    nReset = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: Busy=%b expected 0", Busy);
    end
  endtask

  task automatic test_frame();
    int l0, f0, lat;
    l0 = n_load;
    f0 = n_ferr;
    valid_cyc = -1;
    exp_q.push_back(7'h2A);
    drive_frame(7'h2A, 1'b1, ^7'h2A, -1, -1);
    lat = valid_cyc - fall_cyc;
    checks++;
    if (iD !== 7'h2A || Valid !== 1'b1) begin
      errors++;
      $display("FAIL frame_data: iD=%h Valid=%b expected 2a/1", iD, Valid);
    end
    checks++;
    if (n_load - l0 != 1 || n_ferr != f0) begin
      errors++;
      $display("FAIL frame_pulses: loads=%0d ferr=%0d expected 1/0", n_load - l0, n_ferr - f0);
    end
    checks++;
    if (valid_cyc < 0 || lat < 70 + PX || lat > 72 + PX) begin
      errors++;
      $display("FAIL frame_latency: %0d cycles expected %0d+-1", lat, 71 + PX);
    end
    checks++;
    if (iLoad !== 1'b0) begin
      errors++;
      $display("FAIL frame_load_width: iLoad=%b expected 0 after one cycle", iLoad);
    end
  endtask

  task automatic test_ack();
    pulse_ack();
    checks++;
    if (Valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: Valid=%b expected 0", Valid);
    end
    pulse_ack();
    checks++;
    if (Valid !== 1'b0 || iD !== 7'h2A) begin
      errors++;
      $display("FAIL ack_idle: Valid=%b iD=%h expected 0/2a", Valid, iD);
    end
  endtask

  task automatic test_glitch();
    int l0, f0, bc;
    l0 = n_load;
    f0 = n_ferr;
    bc = 0;
    Rx = 1'b0;
    repeat (2) @(negedge CLK);
    Rx = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (Busy) bc++;
    end
    checks++;
    if (bc < 1 || bc > DIV / 2 + 3) begin
      errors++;
      $display("FAIL glitch_busy: busy %0d cycles expected 1..%0d", bc, DIV / 2 + 3);
    end
    checks++;
    if (n_load != l0 || n_ferr != f0 || Valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_quiet: loads=%0d ferr=%0d Valid=%b expected 0/0/0", n_load - l0, n_ferr - f0, Valid);
    end
  endtask

  task automatic test_stop_err();
    int l0, f0;
    l0 = n_load;
    f0 = n_ferr;
    drive_frame(7'h15, 1'b0, ^7'h15, -1, -1);
    repeat (2) @(negedge CLK);
    checks++;
    if (n_ferr - f0 != 1 || n_load != l0) begin
      errors++;
      $display("FAIL stop_err_pulse: ferr=%0d loads=%0d expected 1/0", n_ferr - f0, n_load - l0);
    end
    checks++;
    if (Valid !== 1'b0 || iD !== 7'h2A) begin
      errors++;
      $display("FAIL stop_err_hold: Valid=%b iD=%h expected 0/2a", Valid, iD);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = n_ovr;
    exp_q.push_back(7'h01);
    drive_frame(7'h01, 1'b1, ^7'h01, -1, -1);
    drive_frame(7'h7F, 1'b1, ^7'h7F, -1, -1);
    checks++;
    if (iD !== 7'h01 || Valid !== 1'b1 || n_ovr - o0 != 1) begin
      errors++;
      $display("FAIL overrun: iD=%h Valid=%b ovr=%0d expected 01/1/1", iD, Valid, n_ovr - o0);
    end
    exp_q.push_back(7'h33);
    drive_frame(7'h33, 1'b1, ^7'h33, -1, 70 + PX);
    checks++;
    if (iD !== 7'h33 || Valid !== 1'b1 || n_ovr - o0 != 1) begin
      errors++;
      $display("FAIL ack_reload: iD=%h Valid=%b ovr=%0d expected 33/1/1", iD, Valid, n_ovr - o0);
    end
    pulse_ack();
  endtask

  task automatic test_enable();
    int l0, f0, o0;
    l0 = n_load;
    f0 = n_ferr;
    o0 = n_ovr;
    drive_frame(7'h55, 1'b1, ^7'h55, 3 * DIV + 2, -1);
    En = 1'b0;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_abort: Busy=%b expected 0", Busy);
    end
    Rx = 1'b1;
    repeat (12 * DIV) @(negedge CLK);
    En = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (n_load != l0 || n_ferr != f0 || n_ovr != o0 || Valid !== 1'b0 || iD !== 7'h33) begin
      errors++;
      $display("FAIL enable_quiet: l/f/o=%0d/%0d/%0d Valid=%b iD=%h expected 0/0/0 0 33",
               n_load - l0, n_ferr - f0, n_ovr - o0, Valid, iD);
    end
  endtask

  task automatic test_reset_mid();
    int l0, f0, o0;
    drive_frame(7'h55, 1'b1, ^7'h55, 5 * DIV + DIV / 2, -1);
    nReset = 1'b0;
    Rx = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({iD, Valid, iLoad, FrameErr, Overrun, Busy} !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid: {iD,V,L,F,O,B}=%h expected 0", {iD, Valid, iLoad, FrameErr, Overrun, Busy});
    end
    nReset = 1'b1;
    l0 = n_load;
    f0 = n_ferr;
    o0 = n_ovr;
    repeat (12 * DIV) @(negedge CLK);
    checks++;
    if (n_load != l0 || n_ferr != f0 || n_ovr != o0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: l/f/o=%0d/%0d/%0d Busy=%b expected 0/0/0 0",
               n_load - l0, n_ferr - f0, n_ovr - o0, Busy);
    end
    exp_q.push_back(7'h40);
    drive_frame(7'h40, 1'b1, ^7'h40, -1, -1);
    checks++;
    if (iD !== 7'h40 || Valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next: iD=%h Valid=%b expected 40/1", iD, Valid);
    end
    pulse_ack();
  endtask

`ifdef TEAMD_RX_PARITY_EN
  task automatic test_parity();
    int f0;
    exp_q.push_back(7'h07);
    drive_frame(7'h07, 1'b1, 1'b1, -1, -1);
    checks++;
    if (iD !== 7'h07 || Valid !== 1'b1) begin
      errors++;
      $display("FAIL parity_good: iD=%h Valid=%b expected 07/1", iD, Valid);
    end
    pulse_ack();
    f0 = n_ferr;
    drive_frame(7'h07, 1'b1, 1'b0, -1, -1);
    checks++;
    if (n_ferr - f0 != 1 || Valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: ferr=%0d Valid=%b expected 1/0", n_ferr - f0, Valid);
    end
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset();
    test_frame();
    test_ack();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef TEAMD_RX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d loads outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
